// File: rtl/hack_vga_pkg.sv
// Shared constants and types for the Hack screen scan-out: default 640x480@60 timing,
// Hack screen geometry (512x256 mono, 16-bit words, 32 words per row) and colours.
package hack_vga_pkg;

  // Default horizontal timing (pixels) and vertical timing (lines)
  localparam int unsigned DEF_H_VIS  = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;
  localparam int unsigned DEF_V_VIS  = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 33;

  localparam int unsigned H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Default placement of the Hack image inside the visible area
  localparam int unsigned DEF_X_OFF = 64;
  localparam int unsigned DEF_Y_OFF = 112;

  // Hack screen geometry
  localparam int unsigned DEF_IMG_W     = 512;
  localparam int unsigned DEF_IMG_H     = 256;
  localparam int unsigned WORD_W        = 16;
  localparam int unsigned WORD_IDX_W    = 4;
  localparam int unsigned WORDS_PER_ROW = DEF_IMG_W / WORD_W;

  // Word fetch is issued this many pixel ticks ahead of the word's first column
  localparam int unsigned FETCH_LEAD = 2;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned RGB_W  = 3;

  localparam logic [RGB_W-1:0] FG_RGB     = 3'b000;
  localparam logic [RGB_W-1:0] BG_RGB     = 3'b111;
  localparam logic [RGB_W-1:0] BORDER_RGB = 3'b001;
  localparam logic [RGB_W-1:0] BLANK_RGB  = 3'b000;

  typedef logic [CNT_W-1:0] cnt_t;

  // Raw per-position decode from the timing generator (sync levels active-low)
  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic visible;
    logic vblank;
  } sync_flags_t;

  // Sum of the four segments of one timing axis
  function automatic int unsigned span_total(input int unsigned vis, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing: 25 MHz pixel enable from the 50 MHz clock, h/v counters and
// combinational sync/visible/vblank decode of the current counter position.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   pix_en_o      high on every other clk; counters advance only on those clks
//   h_cnt_o       horizontal position 0..H_TOTAL-1
//   v_cnt_o       vertical position 0..V_TOTAL-1
//   flags_c_o     decode of the current h/v (not registered)
module vga_timing_gen
  import hack_vga_pkg::*;
#(
  parameter int unsigned H_VIS  = DEF_H_VIS,
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned H_SYNC = DEF_H_SYNC,
  parameter int unsigned H_BP   = DEF_H_BP,
  parameter int unsigned V_VIS  = DEF_V_VIS,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        pix_en_o,
  output cnt_t        h_cnt_o,
  output cnt_t        v_cnt_o,
  output sync_flags_t flags_c_o
);

  localparam cnt_t H_LAST   = CNT_W'(span_total(H_VIS, H_FP, H_SYNC, H_BP) - 1);
  localparam cnt_t V_LAST   = CNT_W'(span_total(V_VIS, V_FP, V_SYNC, V_BP) - 1);
  localparam cnt_t H_VIS_C  = CNT_W'(H_VIS);
  localparam cnt_t V_VIS_C  = CNT_W'(V_VIS);
  localparam cnt_t HS_START = CNT_W'(H_VIS + H_FP);
  localparam cnt_t HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam cnt_t VS_START = CNT_W'(V_VIS + V_FP);
  localparam cnt_t VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic pix_en_q, pix_en_d;
  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  // Counter advance on pixel-enable clks
  always_comb begin
    pix_en_d = ~pix_en_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    if (pix_en_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_en_q <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
    end else begin
      pix_en_q <= pix_en_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
    end
  end

  // Position decode
  always_comb begin
    flags_c_o.hsync_n = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    flags_c_o.vsync_n = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    flags_c_o.visible = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    flags_c_o.vblank  = (v_cnt_q >= V_VIS_C);
  end

  assign pix_en_o = pix_en_q;
  assign h_cnt_o  = h_cnt_q;
  assign v_cnt_o  = v_cnt_q;

endmodule

// File: rtl/hack_vga_scanout.sv
// Hack screen-map scan-out to 3-bit VGA: fetches 16-bit screen words one word ahead of
// display, serialises them LSB-first into the centred image window and registers
// pixel colour, syncs, vblank and frame_start from the same raster position.
// Ports:
//   clk, reset_n  50 MHz clock, asynchronous active-low reset
//   scr_addr      screen word address row*32 + col/16
//   scr_rd_en     one-clk read strobe; scr_data is captured on the following clk
//   scr_data      screen read data (latency 1)
//   pix           {R,G,B} colour
//   hsync, vsync  active-low syncs
//   vblank        high during vertical blanking lines
//   frame_start   one-clk pulse at raster position h=0, v=0
module hack_vga_scanout
  import hack_vga_pkg::*;
#(
  parameter int unsigned H_VIS  = DEF_H_VIS,
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned H_SYNC = DEF_H_SYNC,
  parameter int unsigned H_BP   = DEF_H_BP,
  parameter int unsigned V_VIS  = DEF_V_VIS,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP,
  parameter int unsigned X_OFF  = DEF_X_OFF,
  parameter int unsigned Y_OFF  = DEF_Y_OFF,
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] scr_addr,
  output logic              scr_rd_en,
  input  logic [WORD_W-1:0] scr_data,
  output logic [RGB_W-1:0]  pix,
  output logic              hsync,
  output logic              vsync,
  output logic              vblank,
  output logic              frame_start
);

  localparam int unsigned ROW_WORDS = IMG_W / WORD_W;
  localparam cnt_t X_LO = CNT_W'(X_OFF);
  localparam cnt_t X_HI = CNT_W'(X_OFF + IMG_W);
  localparam cnt_t Y_LO = CNT_W'(Y_OFF);
  localparam cnt_t Y_HI = CNT_W'(Y_OFF + IMG_H);
  localparam cnt_t F_LO = CNT_W'(X_OFF - FETCH_LEAD);
  localparam cnt_t F_HI = CNT_W'(X_OFF - FETCH_LEAD + IMG_W);

  logic        pix_en;
  cnt_t        h_cnt, v_cnt;
  sync_flags_t flags_c;

  vga_timing_gen #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_timing (
    .clk       (clk),
    .reset_n   (reset_n),
    .pix_en_o  (pix_en),
    .h_cnt_o   (h_cnt),
    .v_cnt_o   (v_cnt),
    .flags_c_o (flags_c)
  );

  logic [RGB_W-1:0]  pix_q, pix_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d, vblank_q, vblank_d;
  logic              frame_start_q, frame_start_d, rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] hold_q, hold_d, shift_q, shift_d;

  logic                  win_v_c, win_h_c, fetch_c, pix_bit_c;
  cnt_t                  row_c, fetch_rel_c;
  logic [WORD_IDX_W-1:0] col_lo_c;
  logic [ADDR_W-1:0]     fetch_addr_c;

  // Window / fetch decode of the current raster position
  always_comb begin
    win_v_c      = (v_cnt >= Y_LO) && (v_cnt < Y_HI);
    win_h_c      = (h_cnt >= X_LO) && (h_cnt < X_HI);
    row_c        = v_cnt - Y_LO;
    col_lo_c     = WORD_IDX_W'(h_cnt - X_LO);
    fetch_rel_c  = h_cnt - F_LO;
    fetch_c      = win_v_c && (h_cnt >= F_LO) && (h_cnt < F_HI) &&
                   (fetch_rel_c[WORD_IDX_W-1:0] == '0);
    fetch_addr_c = ADDR_W'(row_c) * ADDR_W'(ROW_WORDS) +
                   ADDR_W'(fetch_rel_c[CNT_W-1:WORD_IDX_W]);
    // First column of a word comes straight from the hold register, which the
    // shift register only picks up on this same tick.
    pix_bit_c    = (col_lo_c == '0) ? hold_q[0] : shift_q[col_lo_c];
  end

  // Next-state: strobes are one clk wide, everything else updates on pixel ticks
  always_comb begin
    pix_d         = pix_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    vblank_d      = vblank_q;
    addr_d        = addr_q;
    hold_d        = hold_q;
    shift_d       = shift_q;
    frame_start_d = 1'b0;
    rd_en_d       = 1'b0;

    if (rd_en_q) begin
      hold_d = scr_data;
    end

    if (pix_en) begin
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      rd_en_d       = fetch_c;
      if (fetch_c) begin
        addr_d = fetch_addr_c;
      end
      if (win_v_c && win_h_c && (col_lo_c == '0)) begin
        shift_d = hold_q;
      end
      hsync_d  = flags_c.hsync_n;
      vsync_d  = flags_c.vsync_n;
      vblank_d = flags_c.vblank;
      if (!flags_c.visible) begin
        pix_d = BLANK_RGB;
      end else if (win_v_c && win_h_c) begin
        pix_d = pix_bit_c ? FG_RGB : BG_RGB;
      end else begin
        pix_d = BORDER_RGB;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
      rd_en_q       <= 1'b0;
      addr_q        <= '0;
      hold_q        <= '0;
      shift_q       <= '0;
    end else begin
      pix_q         <= pix_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
      rd_en_q       <= rd_en_d;
      addr_q        <= addr_d;
      hold_q        <= hold_d;
      shift_q       <= shift_d;
    end
  end

  assign pix         = pix_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;
  assign scr_rd_en   = rd_en_q;
  assign scr_addr    = addr_q;

endmodule

// File: tb/tb_hack_vga_scanout.sv
// Bench for hack_vga_scanout on a scaled-down raster (same rules, smaller numbers) so that
// several whole frames fit in a short run. Expected outputs come from the raster position
// implied by elapsed clocks since reset release and the screen-memory contents.
module tb_hack_vga_scanout;

  localparam int HV = 80, HFP = 4, HS = 8, HBP = 8, HT = HV + HFP + HS + HBP;
  localparam int VV = 20, VFP = 2, VS = 2, VBP = 3, VT = VV + VFP + VS + VBP;
  localparam int XO = 8, YO = 4, IW = 64, IH = 8, WPR = IW / 16;
  localparam int FRAME_CLK = 2 * HT * VT;
  localparam logic [2:0] FG = 3'b000, BG = 3'b111, BORDER = 3'b001;

  typedef struct packed {
    logic [2:0]  pix;
    logic        hs;
    logic        vs;
    logic        vb;
    logic        fs;
    logic        rd;
    logic [12:0] addr;
  } obs_t;

  logic        clk;
  logic        reset_n;
  logic [12:0] scr_addr;
  logic        scr_rd_en;
  logic [15:0] scr_data;
  logic [2:0]  pix;
  logic        hsync, vsync, vblank, frame_start;

  int compared   = 0;
  int mismatched = 0;
  int mode       = 0;   // 0: word = address, 1: all ones, 2: random memory
  bit x_mode     = 1'b0;
  logic [15:0] rnd_mem [0:8191];

  hack_vga_scanout #(
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .X_OFF(XO), .Y_OFF(YO), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .scr_addr(scr_addr), .scr_rd_en(scr_rd_en),
    .scr_data(scr_data), .pix(pix), .hsync(hsync), .vsync(vsync),
    .vblank(vblank), .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input int a);
    if (mode == 0) return 16'(a);
    if (mode == 1) return 16'hFFFF;
    return rnd_mem[a];
  endfunction

  // Screen memory: data valid through the clk after the strobe, garbage otherwise
  always @(negedge clk) begin
    if (scr_rd_en) scr_data <= mem_word(int'(scr_addr));
    else if (x_mode) scr_data <= 'x;
    else scr_data <= 16'($urandom);
  end

  // Raster position of the most recent pixel tick after edge e (ticks at edges 2,4,...)
  function automatic void pos_at(input int e, output int h, output int v);
    int n;
    n = e / 2 - 1;
    h = n % HT;
    v = (n / HT) % VT;
  endfunction

  function automatic bit vis_at(input int e);
    int h, v;
    if (e < 2) return 1'b0;
    pos_at(e, h, v);
    return (h < HV) && (v < VV);
  endfunction

  // Expected outputs after the e-th rising edge following reset release
  function automatic obs_t model(input int e);
    obs_t o;
    int h, v, row, col, hf;
    logic [15:0] w;
    o.pix = 3'b000; o.hs = 1'b1; o.vs = 1'b1; o.vb = 1'b0;
    o.fs = 1'b0; o.rd = 1'b0; o.addr = 13'd0;
    if (e < 2) return o;
    pos_at(e, h, v);
    o.hs = !(h >= HV + HFP && h < HV + HFP + HS);
    o.vs = !(v >= VV + VFP && v < VV + VFP + VS);
    o.vb = (v >= VV);
    if (h < HV && v < VV) begin
      if (h >= XO && h < XO + IW && v >= YO && v < YO + IH) begin
        row = v - YO;
        col = h - XO;
        w = mem_word(row * WPR + col / 16);
        o.pix = w[col % 16] ? FG : BG;
      end else begin
        o.pix = BORDER;
      end
    end
    if (e % 2 == 0) begin
      o.fs = (h == 0) && (v == 0);
      hf = h + 2 - XO;
      if (v >= YO && v < YO + IH && hf >= 0 && hf < IW && hf % 16 == 0) begin
        o.rd = 1'b1;
        o.addr = 13'((v - YO) * WPR + hf / 16);
      end
    end
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.pix = pix; o.hs = hsync; o.vs = vsync; o.vb = vblank;
    o.fs = frame_start; o.rd = scr_rd_en;
    o.addr = scr_rd_en ? scr_addr : 13'd0;
    return o;
  endfunction

  // Called at posedge+1; leaves reset released at posedge+1
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      got = observe(); exp = model(0);
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
    reset_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      got = observe(); exp = model(e);
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL reset_release e=%0d got=%h exp=%h", e, got, exp);
      end
    end
  endtask

  task automatic test_timing_random();
    obs_t got, exp;
    int tfail = 0, rd_cnt = 0, max_addr = 0, hs_fall = -1, vs_fall = -1;
    int hs_per = 0, vs_per = 0;
    logic hs_prev = 1'b1, vs_prev = 1'b1;
    mode = 2; x_mode = 1'b0;
    for (int a = 0; a < 8192; a++) rnd_mem[a] = 16'($urandom);
    do_reset();
    for (int e = 1; e <= 2 * FRAME_CLK + 200; e++) begin
      @(posedge clk); #1;
      got = observe(); exp = model(e);
      compared++;
      if (got !== exp) begin
        mismatched++; tfail++;
        $display("FAIL random_frame e=%0d got=%h exp=%h", e, got, exp);
        if (tfail >= 8) break;
      end
      if (scr_rd_en) begin
        rd_cnt++;
        if (int'(scr_addr) > max_addr) max_addr = int'(scr_addr);
      end
      if (hs_prev && !hsync) begin
        if (hs_fall >= 0) begin
          compared++; hs_per++;
          if (e - hs_fall != 2 * HT) begin
            mismatched++;
            $display("FAIL hsync_period got=%0d exp=%0d", e - hs_fall, 2 * HT);
          end
        end
        hs_fall = e;
      end
      if (!hs_prev && hsync && hs_fall >= 0) begin
        compared++;
        if (e - hs_fall != 2 * HS) begin
          mismatched++;
          $display("FAIL hsync_low got=%0d exp=%0d", e - hs_fall, 2 * HS);
        end
      end
      if (vs_prev && !vsync) begin
        if (vs_fall >= 0) begin
          compared++; vs_per++;
          if (e - vs_fall != 2 * HT * VT) begin
            mismatched++;
            $display("FAIL vsync_period got=%0d exp=%0d", e - vs_fall, 2 * HT * VT);
          end
        end
        vs_fall = e;
      end
      if (!vs_prev && vsync && vs_fall >= 0) begin
        compared++;
        if (e - vs_fall != 2 * HT * VS) begin
          mismatched++;
          $display("FAIL vsync_low got=%0d exp=%0d", e - vs_fall, 2 * HT * VS);
        end
      end
      hs_prev = hsync; vs_prev = vsync;
    end
    compared++;
    if (rd_cnt != 2 * IH * WPR) begin
      mismatched++; $display("FAIL rd_count got=%0d exp=%0d", rd_cnt, 2 * IH * WPR);
    end
    compared++;
    if (max_addr != IH * WPR - 1) begin
      mismatched++; $display("FAIL max_addr got=%0d exp=%0d", max_addr, IH * WPR - 1);
    end
    compared++;
    if (hs_per < 2 * VT - 1 || vs_per != 1) begin
      mismatched++;
      $display("FAIL sync_periods_seen got=%0d/%0d exp>=%0d/1", hs_per, vs_per, 2 * VT - 1);
    end
  endtask

  task automatic test_addr_pattern();
    obs_t got, exp;
    int tfail = 0, fg_cnt = 0, fg_exp = 0;
    mode = 0; x_mode = 1'b0;
    for (int a = 0; a < IH * WPR; a++) fg_exp += $countones(16'(a));
    do_reset();
    for (int e = 1; e <= FRAME_CLK; e++) begin
      @(posedge clk); #1;
      got = observe(); exp = model(e);
      compared++;
      if (got !== exp) begin
        mismatched++; tfail++;
        $display("FAIL addr_pattern e=%0d got=%h exp=%h", e, got, exp);
        if (tfail >= 8) break;
      end
      if (e % 2 == 0 && vis_at(e) && pix == FG) fg_cnt++;
    end
    compared++;
    if (fg_cnt != fg_exp) begin
      mismatched++; $display("FAIL addr_pattern_fg got=%0d exp=%0d", fg_cnt, fg_exp);
    end
  endtask

  task automatic test_all_ones_x();
    obs_t got, exp;
    int tfail = 0, fg_cnt = 0, rd_cnt = 0, max_addr = 0, unk = 0;
    mode = 1; x_mode = 1'b1;
    do_reset();
    for (int e = 1; e <= FRAME_CLK; e++) begin
      @(posedge clk); #1;
      if ($isunknown({pix, hsync, vsync, vblank, frame_start})) unk++;
      got = observe(); exp = model(e);
      compared++;
      if (got !== exp) begin
        mismatched++; tfail++;
        $display("FAIL all_ones e=%0d got=%h exp=%h", e, got, exp);
        if (tfail >= 8) break;
      end
      if (e % 2 == 0 && vis_at(e) && pix == FG) fg_cnt++;
      if (scr_rd_en) begin
        rd_cnt++;
        if (int'(scr_addr) > max_addr) max_addr = int'(scr_addr);
      end
    end
    x_mode = 1'b0;
    compared++;
    if (fg_cnt != IW * IH) begin
      mismatched++; $display("FAIL all_ones_fg got=%0d exp=%0d", fg_cnt, IW * IH);
    end
    compared++;
    if (rd_cnt != IH * WPR) begin
      mismatched++; $display("FAIL all_ones_rd got=%0d exp=%0d", rd_cnt, IH * WPR);
    end
    compared++;
    if (max_addr != IH * WPR - 1) begin
      mismatched++; $display("FAIL all_ones_max_addr got=%0d exp=%0d", max_addr, IH * WPR - 1);
    end
    compared++;
    if (unk != 0) begin
      mismatched++; $display("FAIL unknown_outputs got=%0d exp=0", unk);
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    int tfail = 0;
    int target = 2 * ((YO + 2) * HT + (XO + 20)) + 2;
    mode = 2; x_mode = 1'b0;
    for (int a = 0; a < 8192; a++) rnd_mem[a] = 16'($urandom);
    do_reset();
    for (int e = 1; e <= target; e++) begin
      @(posedge clk); #1;
      got = observe(); exp = model(e);
      compared++;
      if (got !== exp) begin
        mismatched++; tfail++;
        $display("FAIL pre_mid_reset e=%0d got=%h exp=%h", e, got, exp);
        if (tfail >= 8) break;
      end
    end
    #1;
    reset_n = 1'b0;
    #1;
    got = observe(); exp = model(0);
    compared++;
    if (got !== exp) begin
      mismatched++; $display("FAIL mid_reset_async got=%h exp=%h", got, exp);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      got = observe();
      compared++;
      if (got !== exp) begin
        mismatched++; $display("FAIL mid_reset_hold cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
    reset_n = 1'b1;
    tfail = 0;
    for (int e = 1; e <= FRAME_CLK + 20; e++) begin
      @(posedge clk); #1;
      got = observe(); exp = model(e);
      compared++;
      if (got !== exp) begin
        mismatched++; tfail++;
        $display("FAIL after_mid_reset e=%0d got=%h exp=%h", e, got, exp);
        if (tfail >= 8) break;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_timing_random();
    test_addr_pattern();
    test_all_ones_x();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
